// File: rtl/count_pkg.sv
// count_pkg: shared types and default widths for the programmable counter.
//   mode_t : WRAP (roll over at the limits, emit tic) or SAT (stick at the limits).
//   N_DEF / M_DEF / P_DEF : default counter, top-bits and prescaler widths.
package count_pkg;

    typedef enum logic {
        WRAP = 1'b0,
        SAT  = 1'b1
    } mode_t;

    localparam int N_DEF = 20;
    localparam int M_DEF = 4;
    localparam int P_DEF = 8;

endpackage

// File: rtl/count_prog_presc_div.sv
// presc_div: enable-gated prescaler. It produces a step once every presc+1
// enabled cycles and keeps its phase while en is low.
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset
//   en    in   advance enable
//   clr   in   synchronous restart of the prescale phase
//   presc in   terminal count (P bits)
//   step  out  high on the enabled cycle where the phase reaches presc
module presc_div
    import count_pkg::*;
#(
    parameter int P = P_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [P-1:0] presc,
    output logic         step
);

    localparam logic [P-1:0] PCNT_ONE = {{(P-1){1'b0}}, 1'b1};

    logic [P-1:0] pcnt_r;

    // The step is taken on the same edge that sees the terminal phase.
    assign step = en && (pcnt_r == presc);

    // Phase counter. If presc drops below the current phase, it rolls over at 2^P-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_r <= {P{1'b0}};
        end else if (clr) begin
            pcnt_r <= {P{1'b0}};
        end else if (step) begin
            pcnt_r <= {P{1'b0}};
        end else if (en) begin
            pcnt_r <= pcnt_r + PCNT_ONE;
        end else begin
            pcnt_r <= pcnt_r;
        end
    end

endmodule

// File: rtl/count_prog.sv
// count_prog: programmable up/down counter with prescaler, runtime modulus,
// parallel load and wrap/saturate behaviour.
//   clk, rst      clock and asynchronous active-high reset
//   en, up        count enable (gates the prescaler) and direction
//   clr, load     synchronous clear (wins) and parallel load of load_val
//   modulus       top terminal value; the range is 0..modulus
//   presc         prescaler terminal; one step every presc+1 enabled cycles
//   mode          WRAP=0 / SAT=1
//   value, count  full register and its top M bits
//   tic           registered one-cycle pulse after a wrap
//   at_max/at_min combinational limit flags
module count_prog
    import count_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF,
    parameter int P = P_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [N-1:0] modulus,
    input  logic [P-1:0] presc,
    input  logic         mode,
    output logic [N-1:0] value,
    output logic [M-1:0] count,
    output logic         tic,
    output logic         at_max,
    output logic         at_min
);

    localparam logic [N-1:0] VAL_ZERO = {N{1'b0}};
    localparam logic [N-1:0] VAL_ONE  = {{(N-1){1'b0}}, 1'b1};

    mode_t        mode_s;
    logic         step_s;
    logic         presc_clr_s;
    logic [N-1:0] value_r;
    logic [N-1:0] value_nxt_s;
    logic         tic_r;
    logic         tic_nxt_s;

    assign mode_s      = mode_t'(mode);
    // A load also restarts the prescale phase, so the next step arrives a full period later.
    assign presc_clr_s = clr | load;

    presc_div #(.P(P)) u_presc_div (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (presc_clr_s),
        .presc (presc),
        .step  (step_s)
    );

    // Next value and wrap flag. Limits are checked before each +1/-1, so arithmetic never overflows.
    always_comb begin
        value_nxt_s = value_r;
        tic_nxt_s   = 1'b0;
        if (clr) begin
            value_nxt_s = VAL_ZERO;
        end else if (load) begin
            value_nxt_s = (load_val > modulus) ? modulus : load_val;
        end else if (step_s) begin
            if (up) begin
                if (value_r < modulus) begin
                    value_nxt_s = value_r + VAL_ONE;
                end else if (mode_s == WRAP) begin
                    value_nxt_s = VAL_ZERO;
                    tic_nxt_s   = 1'b1;
                end else begin
                    value_nxt_s = modulus;
                end
            end else begin
                if (value_r == VAL_ZERO) begin
                    if (mode_s == WRAP) begin
                        value_nxt_s = modulus;
                        tic_nxt_s   = 1'b1;
                    end else begin
                        value_nxt_s = VAL_ZERO;
                    end
                end else if (value_r > modulus) begin
                    // The modulus was lowered below the value. Snap to the new top without a wrap.
                    value_nxt_s = modulus;
                end else begin
                    value_nxt_s = value_r - VAL_ONE;
                end
            end
        end else begin
            value_nxt_s = value_r;
        end
    end

    // Counter and tic registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_r <= VAL_ZERO;
            tic_r   <= 1'b0;
        end else begin
            value_r <= value_nxt_s;
            tic_r   <= tic_nxt_s;
        end
    end

    assign value  = value_r;
    assign count  = value_r[N-1 -: M];
    assign tic    = tic_r;
    assign at_max = (value_r >= modulus);
    assign at_min = (value_r == VAL_ZERO);

endmodule

// File: tb/tb_count_prog.sv
// Directed testbench for count_prog with N=8, M=4, P=4. Expected values are hand-computed.
module tb_count_prog;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] modulus;
    logic [3:0] presc;
    logic       mode;
    logic [7:0] value;
    logic [3:0] count;
    logic       tic;
    logic       at_max;
    logic       at_min;

    int n_cmp = 0;
    int n_err = 0;

    count_prog #(.N(8), .M(4), .P(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .modulus  (modulus),
        .presc    (presc),
        .mode     (mode),
        .value    (value),
        .count    (count),
        .tic      (tic),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        int exp3 [13] = '{1, 0, 0, 0, 0, 1, 2, 3, 4, 5, 5, 5, 5};

        rst = 1'b1; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 8'd0; modulus = 8'd9; presc = 4'd0; mode = 1'b0;
        #12;
        check_val("rst_value", value, 8'd0);
        check_val("rst_tic", tic, 1'b0);
        check_val("rst_at_min", at_min, 1'b1);
        check_val("rst_at_max", at_max, 1'b0);

        // 1: wrap at modulus 9, step on every enabled cycle
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_val("s1_value", value, exp1[i]);
            check_val("s1_tic", tic, (i == 9) ? 1'b1 : 1'b0);
            check_val("s1_count", count, 4'd0);
        end

        // 2: prescale by 4, pause mid-phase, resume without losing phase
        clr = 1'b1; tick(); clr = 1'b0;
        presc = 4'd3; modulus = 8'd255;
        for (int i = 1; i <= 18; i++) begin
            tick();
            check_val("s2_value", value, i / 4);
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("s2_hold", value, 8'd4);
        end
        en = 1'b1;
        tick(); check_val("s2_resume1", value, 8'd4);
        tick(); check_val("s2_resume2", value, 8'd5);

        // 3: saturate down from 2, then up to modulus 5
        presc = 4'd0; mode = 1'b1; modulus = 8'd5;
        load_val = 8'd2; load = 1'b1; tick(); load = 1'b0;
        check_val("s3_load", value, 8'd2);
        up = 1'b0;
        for (int i = 0; i < 13; i++) begin
            if (i == 5) up = 1'b1;
            tick();
            check_val("s3_value", value, exp3[i]);
            check_val("s3_tic", tic, 1'b0);
            if (i == 4) check_val("s3_at_min", at_min, 1'b1);
        end
        check_val("s3_at_max", at_max, 1'b1);

        // 4: clamped load, clr beats load, down wrap from 0
        mode = 1'b0; en = 1'b0; modulus = 8'd100; load_val = 8'd200;
        load = 1'b1; tick();
        check_val("s4_clamp", value, 8'd100);
        check_val("s4_count", count, 4'd6);
        check_val("s4_at_max", at_max, 1'b1);
        clr = 1'b1; tick(); clr = 1'b0; load = 1'b0;
        check_val("s4_clr_wins", value, 8'd0);
        up = 1'b0; en = 1'b1; tick(); en = 1'b0;
        check_val("s4_wrap_value", value, 8'd100);
        check_val("s4_wrap_tic", tic, 1'b1);
        tick();
        check_val("s4_tic_drop", tic, 1'b0);

        // 5: modulus lowered below the value
        modulus = 8'd255; load_val = 8'd50; load = 1'b1; tick(); load = 1'b0;
        modulus = 8'd20; up = 1'b1;
        #1 check_val("s5_at_max_above", at_max, 1'b1);
        en = 1'b1; tick(); en = 1'b0;
        check_val("s5_up_value", value, 8'd0);
        check_val("s5_up_tic", tic, 1'b1);
        modulus = 8'd255; load = 1'b1; tick(); load = 1'b0;
        modulus = 8'd20; up = 1'b0; en = 1'b1; tick(); en = 1'b0;
        check_val("s5_dn_value", value, 8'd20);
        check_val("s5_dn_tic", tic, 1'b0);

        // 6: asynchronous reset mid-phase (value=7, phase=2)
        modulus = 8'd255; presc = 4'd3; up = 1'b1;
        load_val = 8'd7; load = 1'b1; tick(); load = 1'b0;
        en = 1'b1; tick(); tick();
        check_val("s6_pre", value, 8'd7);
        #3 rst = 1'b1;
        #1 check_val("s6_async_value", value, 8'd0);
        check_val("s6_async_tic", tic, 1'b0);
        #1 rst = 1'b0;
        tick(); tick(); tick();
        check_val("s6_no_early_step", value, 8'd0);
        tick();
        check_val("s6_first_step", value, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
